// File: rtl/mouse_click_conditioner.sv
// Mouse button conditioning for the duck game: per-button sync + debounce FSM,
// single-cycle click pulses, left/right arbitration, shot capture and counting.

module mouse_click_conditioner_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic press
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  localparam logic [31:0] CNT_LOAD = 32'(DEBOUNCE_CYCLES - 1);

  btn_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        meta_q, sync_q, db_q, db_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      meta_q  <= raw;
      sync_q  <= meta_q;
      db_q    <= db_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_LOAD;
        end
      end
      PRESS_CHK: begin
        if (!sync_q) begin
          state_d = RELEASED;
        end else if (cnt_q == '0) begin
          state_d = PRESSED;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_LOAD;
        end
      end
      RELEASE_CHK: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == '0) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = RELEASED;
    endcase
    db_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
  end

  assign db = db_q;

endmodule

module mouse_click_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned X_MAX           = 1023,
  parameter int unsigned Y_MAX           = 767
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_enable,
  input  logic        left_mouse_raw,
  input  logic        right_mouse_raw,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        left_mouse_db,
  output logic        right_mouse_db,
  output logic        left_click,
  output logic        right_click,
  output logic        shot_valid,
  output logic [11:0] shot_xpos,
  output logic [11:0] shot_ypos,
  output logic [7:0]  shots_fired
);

  localparam logic [11:0] X_LIM = 12'(X_MAX);
  localparam logic [11:0] Y_LIM = 12'(Y_MAX);

  logic        l_press, r_press;
  logic        left_click_q, left_click_d;
  logic        right_click_q, right_click_d;
  logic        pending_q, pending_d;
  logic [11:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic [7:0]  shots_q, shots_d;

  mouse_click_conditioner_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .rst_n(rst_n), .raw(left_mouse_raw), .db(left_mouse_db), .press(l_press)
  );

  mouse_click_conditioner_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .rst_n(rst_n), .raw(right_mouse_raw), .db(right_mouse_db), .press(r_press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_click_q  <= 1'b0;
      right_click_q <= 1'b0;
      pending_q     <= 1'b0;
      shot_x_q      <= '0;
      shot_y_q      <= '0;
      shots_q       <= '0;
    end else begin
      left_click_q  <= left_click_d;
      right_click_q <= right_click_d;
      pending_q     <= pending_d;
      shot_x_q      <= shot_x_d;
      shot_y_q      <= shot_y_d;
      shots_q       <= shots_d;
    end
  end

  always_comb begin
    left_click_d  = game_enable && l_press;
    // Left wins a tie; a right press landing while one is pending merges into it.
    right_click_d = game_enable && (pending_q || (r_press && !l_press));
    pending_d     = game_enable && l_press && r_press && !pending_q;
    shot_x_d      = shot_x_q;
    shot_y_d      = shot_y_q;
    shots_d       = shots_q;
    if (left_click_d) begin
      shot_x_d = (mouse_xpos > X_LIM) ? X_LIM : mouse_xpos;
      shot_y_d = (mouse_ypos > Y_LIM) ? Y_LIM : mouse_ypos;
      if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
    end
    if (!game_enable) shots_d = '0;
  end

  assign left_click  = left_click_q;
  assign right_click = right_click_q;
  assign shot_valid  = left_click_q;
  assign shot_xpos   = shot_x_q;
  assign shot_ypos   = shot_y_q;
  assign shots_fired = shots_q;

endmodule

// File: tb/tb_mouse_click_conditioner.sv
// Directed self-checking bench for mouse_click_conditioner (default parameters).

module tb_mouse_click_conditioner;

  logic        clk = 1'b0;
  logic        rst_n, game_enable, left_mouse_raw, right_mouse_raw;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        left_mouse_db, right_mouse_db, left_click, right_click, shot_valid;
  logic [11:0] shot_xpos, shot_ypos;
  logic [7:0]  shots_fired;

  int tests = 0;
  int fails = 0;

  mouse_click_conditioner dut (
    .clk(clk), .rst_n(rst_n), .game_enable(game_enable),
    .left_mouse_raw(left_mouse_raw), .right_mouse_raw(right_mouse_raw),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .left_mouse_db(left_mouse_db), .right_mouse_db(right_mouse_db),
    .left_click(left_click), .right_click(right_click), .shot_valid(shot_valid),
    .shot_xpos(shot_xpos), .shot_ypos(shot_ypos), .shots_fired(shots_fired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [11:0] x, y;
    int          exp_pulses;
    logic [11:0] exp_x, exp_y;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock edge and sample at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int valid_mismatch = 0;

  task automatic click_left(input int hold, input int rel, output int pulses,
                            output logic [11:0] sx, output logic [11:0] sy);
    pulses = 0;
    sx = 12'hFFF;
    sy = 12'hFFF;
    left_mouse_raw = 1'b1;
    for (int i = 0; i < hold + rel; i++) begin
      if (i == hold) left_mouse_raw = 1'b0;
      step();
      if (shot_valid !== left_click) valid_mismatch++;
      if (left_click) begin
        pulses++;
        sx = shot_xpos;
        sy = shot_ypos;
      end
    end
  endtask

  vec_t vecs[7];
  int   exp_shots;
  int   pulses, lcnt, rcnt, lfirst, rfirst;
  logic [11:0] sx, sy, exp_sx, exp_sy;
  logic db_bad;

  initial begin
    vecs[0] = '{1'b1, 12'd300,  12'd200,  1, 12'd300,  12'd200};
    vecs[1] = '{1'b1, 12'd1500, 12'd4000, 1, 12'd1023, 12'd767};
    vecs[2] = '{1'b1, 12'd1023, 12'd767,  1, 12'd1023, 12'd767};
    vecs[3] = '{1'b1, 12'd1024, 12'd768,  1, 12'd1023, 12'd767};
    vecs[4] = '{1'b1, 12'd0,    12'd0,    1, 12'd0,    12'd0};
    vecs[5] = '{1'b1, 12'd4095, 12'd5,    1, 12'd1023, 12'd5};
    vecs[6] = '{1'b0, 12'd77,   12'd88,   0, 12'hFFF,  12'hFFF};

    rst_n = 1'b0; game_enable = 1'b1; left_mouse_raw = 1'b0; right_mouse_raw = 1'b0;
    mouse_xpos = 12'd300; mouse_ypos = 12'd200;
    @(negedge clk);
    repeat (3) step();
    chk("rst_outputs", {left_mouse_db, right_mouse_db, left_click, right_click, shot_valid,
                        shot_xpos, shot_ypos, shots_fired}, '0);
    rst_n = 1'b1;
    step();

    // Clean press: raw first sampled high at edge 0, pulse visible after edge 18.
    left_mouse_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("clean_click_e%0d", k), left_click, (k == 18));
      chk($sformatf("clean_valid_e%0d", k), shot_valid, (k == 18));
      chk($sformatf("clean_db_e%0d", k), left_mouse_db, (k >= 18));
    end
    chk("clean_shot_x", shot_xpos, 300);
    chk("clean_shot_y", shot_ypos, 200);
    chk("clean_shots", shots_fired, 1);
    left_mouse_raw = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      chk($sformatf("release_db_e%0d", k), left_mouse_db, (k < 18));
      chk($sformatf("release_click_e%0d", k), left_click, 0);
    end
    exp_shots = 1;
    exp_sx = 12'd300;
    exp_sy = 12'd200;

    // Table of clicks at various cursor positions / enable states.
    foreach (vecs[i]) begin
      game_enable = vecs[i].en;
      mouse_xpos = vecs[i].x;
      mouse_ypos = vecs[i].y;
      click_left(25, 25, pulses, sx, sy);
      if (vecs[i].exp_pulses > 0) begin
        exp_sx = vecs[i].exp_x;
        exp_sy = vecs[i].exp_y;
        chk($sformatf("vec%0d_shot_x", i), sx, exp_sx);
        chk($sformatf("vec%0d_shot_y", i), sy, exp_sy);
      end
      exp_shots = vecs[i].en ? ((exp_shots + vecs[i].exp_pulses > 255) ? 255
                                 : exp_shots + vecs[i].exp_pulses) : 0;
      chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("vec%0d_hold_x", i), shot_xpos, exp_sx);
      chk($sformatf("vec%0d_hold_y", i), shot_ypos, exp_sy);
      chk($sformatf("vec%0d_shots", i), shots_fired, exp_shots);
    end
    game_enable = 1'b1;
    step();

    // Glitch rejection: short press then bounce shorter than the debounce window.
    left_mouse_raw = 1'b1;
    repeat (10) step();
    left_mouse_raw = 1'b0;
    repeat (10) step();
    lcnt = 0; db_bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k < 36 && (k % 3) == 0) left_mouse_raw = ~left_mouse_raw;
      if (k == 36) left_mouse_raw = 1'b0;
      step();
      if (left_click) lcnt++;
      if (left_mouse_db) db_bad = 1'b1;
    end
    chk("glitch_clicks", lcnt, 0);
    chk("glitch_db", db_bad, 0);
    chk("glitch_shots", shots_fired, 0);

    // Simultaneous press: left wins, right follows one cycle later.
    lcnt = 0; rcnt = 0; lfirst = -1; rfirst = -1;
    left_mouse_raw = 1'b1; right_mouse_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (left_click) begin lcnt++; if (lfirst < 0) lfirst = k; end
      if (right_click) begin rcnt++; if (rfirst < 0) rfirst = k; end
    end
    chk("simul_left_cnt", lcnt, 1);
    chk("simul_right_cnt", rcnt, 1);
    chk("simul_left_edge", lfirst, 18);
    chk("simul_right_edge", rfirst, 19);
    chk("simul_right_db", right_mouse_db, 1);
    left_mouse_raw = 1'b0; right_mouse_raw = 1'b0;
    repeat (25) step();

    // Saturation after 300 clean clicks.
    mouse_xpos = 12'd10; mouse_ypos = 12'd20;
    lcnt = 0;
    for (int n = 0; n < 300; n++) begin
      click_left(20, 20, pulses, sx, sy);
      lcnt += pulses;
    end
    chk("sat_clicks", lcnt, 300);
    chk("sat_shots", shots_fired, 255);
    chk("valid_tracks_click", valid_mismatch, 0);

    // Enable gating: a press held across the enable edge never pulses.
    game_enable = 1'b0;
    step();
    chk("gate_clear_shots", shots_fired, 0);
    left_mouse_raw = 1'b1;
    lcnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 30) game_enable = 1'b1;
      step();
      if (left_click || shot_valid) lcnt++;
    end
    chk("gate_held_no_pulse", lcnt, 0);
    chk("gate_held_db", left_mouse_db, 1);
    left_mouse_raw = 1'b0;
    repeat (25) step();
    click_left(25, 25, pulses, sx, sy);
    chk("gate_new_press", pulses, 1);
    chk("gate_shots_one", shots_fired, 1);

    // Enable drops while right is pending.
    lcnt = 0; rcnt = 0;
    left_mouse_raw = 1'b1; right_mouse_raw = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (left_click) lcnt++;
      if (right_click) rcnt++;
      if (k == 18) game_enable = 1'b0;
    end
    chk("pend_drop_left", lcnt, 1);
    chk("pend_drop_right", rcnt, 0);
    chk("pend_drop_shots", shots_fired, 0);
    left_mouse_raw = 1'b0; right_mouse_raw = 1'b0;
    repeat (25) step();
    game_enable = 1'b1;
    step();

    // Reset mid-debounce (cnt=5 in PRESS_CHK after edge 12), button kept held.
    left_mouse_raw = 1'b1;
    lcnt = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      if (left_click) lcnt++;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_no_early", lcnt, 0);
    chk("midrst_outputs", {left_mouse_db, right_mouse_db, left_click, right_click, shot_valid,
                           shot_xpos, shot_ypos, shots_fired}, '0);
    lcnt = 0; lfirst = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (left_click) begin lcnt++; if (lfirst < 0) lfirst = k; end
    end
    chk("midrst_clicks", lcnt, 1);
    chk("midrst_edge", lfirst, 18);
    chk("midrst_shots", shots_fired, 1);
    left_mouse_raw = 1'b0;
    repeat (25) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
